commit_sequencer: RTL and testbench
===================================

COMMIT_SEQUENCER -- requirements
Module: commit_sequencer

Interface
REQ-001 SHALL have parameter NRET, default 2: number of commit ports; port 0 is oldest in program order.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries; power of two, at least NRET.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port uop_entry_i, input, NRET x connector_pkg::uop_entry_s: per-port commit entries.
REQ-006 SHALL have port cause_i, input, XLEN: trap cause, valid in the cycle a trap entry is presented.
REQ-007 SHALL have port tval_i, input, XLEN: trap value, valid in the same cycle as cause_i.
REQ-008 SHALL have port ready_i, input, 1: downstream fsm accepts uop_entry_o this cycle; tie high when unused.
REQ-009 SHALL have port uop_entry_o, output, connector_pkg::uop_entry_s: serialized entry to the fsm.
REQ-010 SHALL have port cause_o, output, XLEN: cause paired with uop_entry_o.
REQ-011 SHALL have port tval_o, output, XLEN: tval paired with uop_entry_o.
REQ-012 SHALL have port count_o, output, $clog2(DEPTH+1): occupancy.
REQ-013 SHALL have port overflow_o, output, 1: sticky drop indicator.

Function
REQ-014 SHALL treat a port entry as live when valid=1 or itype is 1 (exception) or 2 (interrupt).
REQ-015 SHALL push all live entries of a cycle in ascending port order into a circular buffer, storing each with cause_i/tval_i; non-trap entries SHALL store cause=tval=0.
REQ-016 SHALL discard live entries on ports above the lowest-indexed trap entry (itype 1 or 2) in the same cycle.
REQ-017 SHALL present the head entry on uop_entry_o/cause_o/tval_o from registers; latency push-to-output is exactly 1 cycle, with no combinational bypass.
REQ-018 SHALL pop the head when ready_i=1 and count_o>0; when ready_i=0, outputs SHALL hold.
REQ-019 SHALL drive uop_entry_o, cause_o and tval_o to all-zero (valid=0, itype=0) when count_o=0.
REQ-020 SHALL accept a cycle's pushes only if count - pop + pushes <= DEPTH, so a same-cycle pop frees its slot first.
REQ-021 SHALL drop all entries of that cycle when the check fails (all-or-nothing), and SHALL set overflow_o until reset.
REQ-022 SHALL have pointers that wrap modulo DEPTH; count_o SHALL never exceed DEPTH.
REQ-023 SHALL implement a state machine with states EMPTY (count=0), ACTIVE (0<count<DEPTH) and FULL (count=DEPTH), with transitions driven solely by the next count value.

Reset
REQ-024 SHALL, on rst_i=1 at a clock edge, set pointers=0, count_o=0, overflow_o=0, state=EMPTY, and all outputs to zero; inputs in that cycle SHALL be ignored.
REQ-025 SHALL discard buffered entries when reset is asserted mid-operation; no partial entry SHALL appear after reset.

Structure
REQ-026 SHALL take NRET and a struct seq_entry_s {uop_entry_s uop; cause; tval} from connector_pkg.
REQ-027 SHALL place buffer storage and pointers in one sub-module, multi_push_fifo (NRET pushes, 1 pop per cycle); trap filtering and compaction SHALL stay in commit_sequencer.

Verification
REQ-028 SHALL cover: port0 std pc=0x100 and port1 std pc=0x104 in one cycle, ready_i=1 -> 0x100 appears next cycle, then 0x104; count_o goes 2,1,0.
REQ-029 SHALL cover: port0 exception (itype=1, valid=0, cause=2, tval=0xDEAD) with port1 std valid -> one entry, cause_o=2, tval_o=0xDEAD; port1 dropped; overflow_o=0.
REQ-030 SHALL cover: ready_i=0 while 2 entries/cycle for 2 cycles -> count_o=4 (FULL); a third double push -> dropped, overflow_o=1, count_o stays 4.
REQ-031 SHALL cover: FULL with ready_i=1 and one push -> accepted, count_o stays 4, and order is preserved across pointer wrap.
REQ-032 SHALL cover: rst_i asserted with count_o=3 -> next cycle count_o=0, uop_entry_o all-zero, overflow_o=0.

Source files
------------

// File: rtl/connector_pkg.sv
// Shared commit-path types: the per-port commit entry and the buffered entry
// that carries its trap cause/value.
package connector_pkg;

    localparam int XLEN = 32;
    localparam int NRET = 2;

    localparam logic [1:0] ITYPE_STD = 2'd0;
    localparam logic [1:0] ITYPE_EXC = 2'd1;
    localparam logic [1:0] ITYPE_INT = 2'd2;

    typedef struct packed {
        logic            valid;
        logic [1:0]      itype;
        logic [XLEN-1:0] pc;
    } uop_entry_s;

    typedef struct packed {
        uop_entry_s      uop;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } seq_entry_s;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_FULL
    } seq_state_e;

    function automatic logic is_trap(input logic [1:0] itype);
        return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
    endfunction

endpackage

// File: rtl/multi_push_fifo.sv
// Circular buffer accepting up to NRET compacted pushes and one pop per cycle.
// A cycle's pushes are taken all-or-nothing after crediting a same-cycle pop.
module multi_push_fifo
    import connector_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(NRET + 1),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [CW-1:0]   push_cnt,
    input  seq_entry_s      push_data [NRET],
    input  logic            ready,
    output seq_entry_s      head,
    output logic [CNTW-1:0] count,
    output logic [CNTW-1:0] count_next,
    output logic            drop
);

    localparam int PW = $clog2(DEPTH);

    seq_entry_s      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CNTW-1:0] count_q;
    logic            pop;
    logic            accept;
    int              occ_after_pop;

    assign pop           = ready && (count_q != '0);
    assign occ_after_pop = int'(count_q) - int'(pop);
    assign accept        = (occ_after_pop + int'(push_cnt)) <= DEPTH;
    assign drop          = !accept;
    assign count_next    = accept ? CNTW'(occ_after_pop + int'(push_cnt))
                                  : CNTW'(occ_after_pop);
    assign head          = mem[rd_ptr];
    assign count         = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(push_cnt);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_next;
        end
    end

    // Storage is not reset; stale slots are never visible while empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept) begin
            for (int i = 0; i < NRET; i++) begin
                if (i < int'(push_cnt)) mem[wr_ptr + PW'(i)] <= push_data[i];
            end
        end
    end

endmodule

// File: rtl/commit_sequencer.sv
// Serializes up to NRET commit entries per cycle into a single stream for the
// downstream fsm, cutting younger ports off at the first trap.
//
// state     | meaning
// ----------+-------------------------------
// ST_EMPTY  | no buffered entries, outputs zero
// ST_ACTIVE | some entries buffered, room left
// ST_FULL   | DEPTH entries buffered
module commit_sequencer
    import connector_pkg::*;
#(
    parameter int NRET  = connector_pkg::NRET,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  uop_entry_s [NRET-1:0]        uop_entry_i,
    input  logic [XLEN-1:0]              cause_i,
    input  logic [XLEN-1:0]              tval_i,
    input  logic                         ready_i,
    output uop_entry_s                   uop_entry_o,
    output logic [XLEN-1:0]              cause_o,
    output logic [XLEN-1:0]              tval_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o
);

    localparam int CW   = $clog2(NRET + 1);
    localparam int CNTW = $clog2(DEPTH + 1);

    seq_entry_s      push_data [NRET];
    logic [CW-1:0]   push_cnt;
    logic            trap_seen;
    seq_entry_s      head;
    logic [CNTW-1:0] count_next;
    logic            drop;
    seq_state_e      state;

    // Compact live ports to the low slots; only trap entries carry cause/tval.
    always_comb begin
        push_cnt  = '0;
        trap_seen = 1'b0;
        for (int k = 0; k < NRET; k++) push_data[k] = '0;
        for (int i = 0; i < NRET; i++) begin
            if (!trap_seen && (uop_entry_i[i].valid || is_trap(uop_entry_i[i].itype))) begin
                push_data[push_cnt].uop = uop_entry_i[i];
                if (is_trap(uop_entry_i[i].itype)) begin
                    push_data[push_cnt].cause = cause_i;
                    push_data[push_cnt].tval  = tval_i;
                    trap_seen = 1'b1;
                end
                push_cnt = push_cnt + CW'(1);
            end
        end
    end

    multi_push_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_cnt   (push_cnt),
        .push_data  (push_data),
        .ready      (ready_i),
        .head       (head),
        .count      (count_o),
        .count_next (count_next),
        .drop       (drop)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_EMPTY;
            overflow_o <= 1'b0;
        end else begin
            if (drop) overflow_o <= 1'b1;
            if (count_next == '0)                state <= ST_EMPTY;
            else if (count_next == CNTW'(DEPTH)) state <= ST_FULL;
            else                                 state <= ST_ACTIVE;
        end
    end

    assign uop_entry_o = (state == ST_EMPTY) ? '0 : head.uop;
    assign cause_o     = (state == ST_EMPTY) ? '0 : head.cause;
    assign tval_o      = (state == ST_EMPTY) ? '0 : head.tval;

endmodule

// File: tb/tb_commit_sequencer.sv
// Directed bench for commit_sequencer with a queue-based reference model
// compared on every falling edge, plus literal expectations per scenario.
module tb_commit_sequencer;
    import connector_pkg::*;

    localparam int NR = 2;
    localparam int DP = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ready;
    uop_entry_s [NR-1:0]  uin;
    logic [XLEN-1:0]      cause_in;
    logic [XLEN-1:0]      tval_in;
    uop_entry_s           uout;
    logic [XLEN-1:0]      cause_out;
    logic [XLEN-1:0]      tval_out;
    logic [2:0]           cnt;
    logic                 ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commit_sequencer #(.NRET(NR), .DEPTH(DP)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uop_entry_i (uin),
        .cause_i     (cause_in),
        .tval_i      (tval_in),
        .ready_i     (ready),
        .uop_entry_o (uout),
        .cause_o     (cause_out),
        .tval_o      (tval_out),
        .count_o     (cnt),
        .overflow_o  (ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of buffered entries.
    seq_entry_s mq[$];
    seq_entry_s arr[$];
    seq_entry_s e;
    logic       m_ovf = 1'b0;
    bit         m_on  = 1'b0;
    bit         stop;
    bit         trap;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_on  = 1'b1;
        end else if (m_on) begin
            arr.delete();
            stop = 1'b0;
            for (int p = 0; p < NR; p++) begin
                trap = (uin[p].itype == 2'd1) || (uin[p].itype == 2'd2);
                if (!stop && (uin[p].valid || trap)) begin
                    e.uop   = uin[p];
                    e.cause = trap ? cause_in : '0;
                    e.tval  = trap ? tval_in : '0;
                    arr.push_back(e);
                    if (trap) stop = 1'b1;
                end
            end
            if (ready && mq.size() > 0) void'(mq.pop_front());
            if (mq.size() + arr.size() <= DP) begin
                foreach (arr[j]) mq.push_back(arr[j]);
            end else begin
                m_ovf = 1'b1;
            end
        end
    end

    seq_entry_s h;
    always @(negedge clk) begin
        if (m_on) begin
            h = (mq.size() > 0) ? mq[0] : '0;
            check("model_uop",   64'(uout),      64'(h.uop));
            check("model_cause", 64'(cause_out), 64'(h.cause));
            check("model_tval",  64'(tval_out),  64'(h.tval));
            check("model_count", 64'(cnt),       64'(mq.size()));
            check("model_ovf",   64'(ovf),       64'(m_ovf));
        end
    end

    task automatic drive(input logic r,
                         input logic v0, input logic [1:0] t0, input logic [31:0] pc0,
                         input logic v1, input logic [1:0] t1, input logic [31:0] pc1,
                         input logic [31:0] c, input logic [31:0] tv);
        ready          = r;
        uin[0].valid   = v0;
        uin[0].itype   = t0;
        uin[0].pc      = pc0;
        uin[1].valid   = v1;
        uin[1].itype   = t1;
        uin[1].pc      = pc1;
        cause_in       = c;
        tval_in        = tv;
    endtask

    task automatic idle(input logic r);
        drive(r, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] drain_pc [4];

    initial begin
        rst = 1'b1;
        idle(1'b1);
        cyc();
        cyc();
        check("rst_count", 64'(cnt), 64'd0);
        check("rst_uop",   64'(uout), 64'd0);
        check("rst_ovf",   64'(ovf), 64'd0);
        rst = 1'b0;

        // two standard entries, drained in order
        drive(1'b1, 1'b1, 2'd0, 32'h100, 1'b1, 2'd0, 32'h104, 32'h0, 32'h0);
        cyc();
        check("dual_count0", 64'(cnt), 64'd2);
        check("dual_pc0",    64'(uout.pc), 64'h100);
        idle(1'b1);
        cyc();
        check("dual_count1", 64'(cnt), 64'd1);
        check("dual_pc1",    64'(uout.pc), 64'h104);
        cyc();
        check("dual_count2", 64'(cnt), 64'd0);
        check("dual_empty",  64'(uout), 64'd0);

        // exception on port 0 cuts port 1
        drive(1'b1, 1'b0, 2'd1, 32'h200, 1'b1, 2'd0, 32'h204, 32'd2, 32'hDEAD);
        cyc();
        check("exc_count", 64'(cnt), 64'd1);
        check("exc_cause", 64'(cause_out), 64'd2);
        check("exc_tval",  64'(tval_out), 64'hDEAD);
        check("exc_pc",    64'(uout.pc), 64'h200);
        check("exc_itype", 64'(uout.itype), 64'd1);
        check("exc_ovf",   64'(ovf), 64'd0);
        idle(1'b1);
        cyc();
        check("exc_drain", 64'(cnt), 64'd0);

        // fill to FULL with ready low, then overflow
        drive(1'b0, 1'b1, 2'd0, 32'h300, 1'b1, 2'd0, 32'h304, 32'h0, 32'h0);
        cyc();
        check("fill_count2", 64'(cnt), 64'd2);
        drive(1'b0, 1'b1, 2'd0, 32'h308, 1'b1, 2'd0, 32'h30C, 32'h0, 32'h0);
        cyc();
        check("fill_count4", 64'(cnt), 64'd4);
        check("fill_hold",   64'(uout.pc), 64'h300);
        drive(1'b0, 1'b1, 2'd0, 32'h310, 1'b1, 2'd0, 32'h314, 32'h0, 32'h0);
        cyc();
        check("ovf_count", 64'(cnt), 64'd4);
        check("ovf_flag",  64'(ovf), 64'd1);
        check("ovf_head",  64'(uout.pc), 64'h300);

        // push while FULL with pop, order kept across wrap
        drive(1'b1, 1'b1, 2'd0, 32'h318, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        cyc();
        check("fullpush_count", 64'(cnt), 64'd4);
        idle(1'b1);
        drain_pc[0] = 32'h304;
        drain_pc[1] = 32'h308;
        drain_pc[2] = 32'h30C;
        drain_pc[3] = 32'h318;
        for (int k = 0; k < 4; k++) begin
            check("wrap_pc",    64'(uout.pc), 64'(drain_pc[k]));
            check("wrap_count", 64'(cnt), 64'(4 - k));
            cyc();
        end
        check("wrap_empty", 64'(cnt), 64'd0);
        check("ovf_sticky", 64'(ovf), 64'd1);

        // interrupt on port 1 behind a standard port 0
        drive(1'b1, 1'b1, 2'd0, 32'h400, 1'b0, 2'd2, 32'h404, 32'h8000000B, 32'h11);
        cyc();
        check("int_count", 64'(cnt), 64'd2);
        check("int_std_cause", 64'(cause_out), 64'd0);
        idle(1'b1);
        cyc();
        check("int_pc",    64'(uout.pc), 64'h404);
        check("int_cause", 64'(cause_out), 64'h8000000B);
        check("int_itype", 64'(uout.itype), 64'd2);
        cyc();

        // only port 1 live; std entry stores zero cause
        drive(1'b1, 1'b0, 2'd0, 32'h4FF, 1'b1, 2'd0, 32'h500, 32'h77, 32'h88);
        cyc();
        check("p1_count", 64'(cnt), 64'd1);
        check("p1_pc",    64'(uout.pc), 64'h500);
        check("p1_tval",  64'(tval_out), 64'd0);
        idle(1'b1);
        cyc();

        // exception on port 1 keeps port 0
        drive(1'b1, 1'b1, 2'd0, 32'h600, 1'b1, 2'd1, 32'h604, 32'd5, 32'd6);
        cyc();
        idle(1'b1);
        cyc();
        check("p1exc_pc",   64'(uout.pc), 64'h604);
        check("p1exc_tval", 64'(tval_out), 64'd6);
        cyc();

        // reset with three buffered entries
        drive(1'b0, 1'b1, 2'd0, 32'h700, 1'b1, 2'd0, 32'h704, 32'h0, 32'h0);
        cyc();
        drive(1'b0, 1'b1, 2'd0, 32'h708, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        cyc();
        check("pre_rst_count", 64'(cnt), 64'd3);
        rst = 1'b1;
        drive(1'b1, 1'b1, 2'd0, 32'h70C, 1'b1, 2'd0, 32'h710, 32'h0, 32'h0);
        cyc();
        check("mid_rst_count", 64'(cnt), 64'd0);
        check("mid_rst_uop",   64'(uout), 64'd0);
        check("mid_rst_ovf",   64'(ovf), 64'd0);
        rst = 1'b0;
        idle(1'b1);
        cyc();
        check("post_rst_count", 64'(cnt), 64'd0);
        check("post_rst_uop",   64'(uout), 64'd0);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
